eth_frame_log_arbiter: RTL and testbench
========================================

ETH_FRAME_LOG_ARBITER -- requirements
Module: eth_frame_log_arbiter

Interface
REQ-001 The block SHALL have parameter C_AXI_WIDTH, default 32, giving the width in bits of log entry data words.
REQ-002 clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  when high, new grants are allowed.
REQ-005 s_a_tdata, s_a_tlast, s_a_tvalid  input  C_AXI_WIDTH,1,1  log entry stream from the iface A detector; s_a_tready  output  1.
REQ-006 s_b_tdata, s_b_tlast, s_b_tvalid  input  C_AXI_WIDTH,1,1  log entry stream from the iface B detector; s_b_tready  output  1.
REQ-007 m_tdata  output  C_AXI_WIDTH, m_tuser  output  1 (0=A, 1=B), m_tlast  output  1, m_tvalid  output  1, m_tready  input  1  merged log stream.
REQ-008 busy  output  1  high while a grant is held.
REQ-009 count_a, count_b  output  32 each, clear_stats  input  1  present only per REQ-027.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT_A and GRANT_B, with a registered last_grant bit.
REQ-011 IDLE, enable=1, only s_a_tvalid: next state GRANT_A; only s_b_tvalid: GRANT_B.
REQ-012 IDLE, enable=1, both valid: grant the source not equal to last_grant (round-robin); update last_grant on entering a grant.
REQ-013 IDLE, enable=0 or no valid: stay IDLE.
REQ-014 Grant decision latency: one cycle from valid observed in IDLE to the first word being presented on m_*.
REQ-015 In GRANT_X, m_tdata/m_tlast/m_tvalid SHALL combinationally mirror source X, m_tuser = X, s_X_tready = m_tready; the other source's tready SHALL be 0.
REQ-016 In IDLE, m_tvalid, s_a_tready and s_b_tready SHALL be 0; m_tdata, m_tlast, m_tuser SHALL be 0.
REQ-017 The grant SHALL be held until a handshake (m_tvalid & m_tready) with m_tlast=1, then return to IDLE the next cycle; entries are never interleaved.
REQ-018 One IDLE cycle (bubble) SHALL separate consecutive entries.
REQ-019 Deasserting enable mid-entry SHALL NOT abort the entry; it completes and the FSM then holds IDLE.
REQ-020 Source dropping tvalid mid-entry SHALL keep the grant; m_tvalid follows it low.
REQ-021 busy = 1 in GRANT_A or GRANT_B, else 0.
REQ-022 Single-word entries (tvalid & tlast on first word) SHALL be handled identically.

Reset
REQ-023 On rst=1 at a clock edge: state IDLE, last_grant = B (so A wins the first tie), all tready/m_tvalid/busy = 0.
REQ-024 Reset mid-entry SHALL drop the grant immediately; partial entry is not completed and the downstream sees m_tvalid=0 the next cycle.
REQ-025 Counters (when compiled in) SHALL reset to 0.

Configuration
REQ-026 Macro ETH_FRAME_LOG_ARBITER_STATS_EN controls statistics.
REQ-027 Defined: count_a/count_b increment by 1 on each handshake with m_tlast=1 from A/B, wrap 0xFFFFFFFF -> 0; clear_stats=1 zeroes both synchronously, taking priority over a same-cycle increment. Not defined: ports count_a, count_b, clear_stats absent; no counter logic.

Verification
REQ-028 After reset, A sends 3-word entry, m_tready=1 -> m_tuser=0, 3 words out in order, first word 1 cycle after valid, busy high 3 cycles.
REQ-029 A and B both valid in IDLE after reset, single-word entries repeated -> output order A,B,A,B with one idle cycle between.
REQ-030 B 4-word entry, m_tready toggled 1,0,1,0... while A asserts valid -> B words intact, s_a_tready=0 throughout, A granted only after B tlast.
REQ-031 enable dropped after word 2 of 5-word A entry -> all 5 words out, then IDLE with both valid held, no grant.
REQ-032 rst pulsed during word 2 of A entry -> m_tvalid=0 next cycle, then B-and-A tie grants A.
REQ-033 STATS_EN defined: 7 A entries, 2 B entries -> count_a=7, count_b=2; clear_stats on same cycle as A tlast -> count_a=0; counter preloaded via 2^32 entries (or forced) wraps to 0.

Source files
------------

// File: rtl/eth_frame_log_arbiter.sv
// Round-robin arbiter merging two log-entry streams into one, holding each grant until tlast.
// Define ETH_FRAME_LOG_ARBITER_STATS_EN to add per-source completed-entry counters.
module eth_frame_log_arbiter #(
  parameter int C_AXI_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [C_AXI_WIDTH-1:0] s_a_tdata,
  input  logic                   s_a_tlast,
  input  logic                   s_a_tvalid,
  output logic                   s_a_tready,
  input  logic [C_AXI_WIDTH-1:0] s_b_tdata,
  input  logic                   s_b_tlast,
  input  logic                   s_b_tvalid,
  output logic                   s_b_tready,
  output logic [C_AXI_WIDTH-1:0] m_tdata,
  output logic                   m_tuser,
  output logic                   m_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   busy
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
  ,
  input  logic                   clear_stats,
  output logic [31:0]            count_a,
  output logic [31:0]            count_b
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t state;
  logic   last_grant;  // 0 = A was granted last, 1 = B
  logic   end_a;
  logic   end_b;

  // An entry ends on the accepted beat that carries tlast.
  assign end_a = (state == GRANT_A) && s_a_tvalid && m_tready && s_a_tlast;
  assign end_b = (state == GRANT_B) && s_b_tvalid && m_tready && s_b_tlast;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && s_a_tvalid && (!s_b_tvalid || last_grant)) begin
            state      <= GRANT_A;
            last_grant <= 1'b0;
            busy       <= 1'b1;
          end else if (enable && s_b_tvalid) begin
            state      <= GRANT_B;
            last_grant <= 1'b1;
            busy       <= 1'b1;
          end
        end
        GRANT_A: begin
          if (end_a) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT_B: begin
          if (end_b) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    m_tdata    = '0;
    m_tuser    = 1'b0;
    m_tlast    = 1'b0;
    m_tvalid   = 1'b0;
    s_a_tready = 1'b0;
    s_b_tready = 1'b0;
    case (state)
      GRANT_A: begin
        m_tdata    = s_a_tdata;
        m_tlast    = s_a_tlast;
        m_tvalid   = s_a_tvalid;
        s_a_tready = m_tready;
      end
      GRANT_B: begin
        m_tdata    = s_b_tdata;
        m_tuser    = 1'b1;
        m_tlast    = s_b_tlast;
        m_tvalid   = s_b_tvalid;
        s_b_tready = m_tready;
      end
      default: ;
    endcase
  end

`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
  // Clear wins over a same-cycle completion; counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      count_a <= '0;
      count_b <= '0;
    end else begin
      count_a <= count_a + {31'd0, end_a};
      count_b <= count_b + {31'd0, end_b};
    end
  end
`endif

endmodule

// File: tb/tb_eth_frame_log_arbiter.sv
// Directed self-checking bench for eth_frame_log_arbiter: ordering, round-robin, backpressure,
// enable drop, mid-entry reset and (with ETH_FRAME_LOG_ARBITER_STATS_EN) counters.
module tb_eth_frame_log_arbiter;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } word_t;

  typedef struct {
    int           cyc;
    logic         user;
    logic [W-1:0] data;
    logic         last;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] s_a_tdata, s_b_tdata, m_tdata;
  logic         s_a_tlast, s_a_tvalid, s_a_tready;
  logic         s_b_tlast, s_b_tvalid, s_b_tready;
  logic         m_tuser, m_tlast, m_tvalid, m_tready, busy;
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
  logic         clear_stats;
  logic [31:0]  count_a, count_b;
`endif

  word_t qa[$];
  word_t qb[$];
  ent_t  out_q[$];
  int    cyc, busy_cycles, a_rdy_early;
  bit    a_on, b_on, toggle_ready, b_done;
  int    checks = 0;
  int    failures = 0;

  eth_frame_log_arbiter #(.C_AXI_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_a_tdata(s_a_tdata), .s_a_tlast(s_a_tlast), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready),
    .s_b_tdata(s_b_tdata), .s_b_tlast(s_b_tlast), .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .busy(busy)
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
    , .clear_stats(clear_stats), .count_a(count_a), .count_b(count_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    s_a_tvalid = a_on && (qa.size() > 0);
    s_a_tdata  = (qa.size() > 0) ? qa[0].d : '0;
    s_a_tlast  = (qa.size() > 0) ? qa[0].l : 1'b0;
    s_b_tvalid = b_on && (qb.size() > 0);
    s_b_tdata  = (qb.size() > 0) ? qb[0].d : '0;
    s_b_tlast  = (qb.size() > 0) ? qb[0].l : 1'b0;
    m_tready   = toggle_ready ? (cyc % 2 == 0) : 1'b1;
  endtask

  task automatic sample();
    if (s_a_tvalid && s_a_tready) void'(qa.pop_front());
    if (s_b_tvalid && s_b_tready) void'(qb.pop_front());
    if (m_tvalid && m_tready) begin
      out_q.push_back('{cyc: cyc, user: m_tuser, data: m_tdata, last: m_tlast});
      if (m_tuser && m_tlast) b_done = 1'b1;
    end
    if (busy) busy_cycles++;
    if (s_a_tready && !b_done) a_rdy_early++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      drive();
      @(negedge clk);
      sample();
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    drive();
    @(negedge clk);
  endtask

  task automatic push(input bit to_b, input logic [W-1:0] d, input logic l);
    if (to_b) qb.push_back('{d: d, l: l});
    else      qa.push_back('{d: d, l: l});
  endtask

  task automatic clear_log();
    out_q.delete();
    cyc = 0;
    busy_cycles = 0;
    a_rdy_early = 0;
    b_done = 1'b0;
  endtask

  task automatic reset_dut();
    qa.delete();
    qb.delete();
    a_on = 1'b1;
    b_on = 1'b1;
    toggle_ready = 1'b0;
    enable = 1'b1;
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
    clear_stats = 1'b0;
`endif
    rst = 1'b1;
    clear_log();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, then a 3-word A entry with first word one cycle after valid
    reset_dut();
    settle();
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_a_tready", s_a_tready, 0);
    check("rst_b_tready", s_b_tready, 0);
    check("rst_m_tdata", m_tdata, 0);
    @(posedge clk); #1;
    push(0, 32'hA0, 0); push(0, 32'hA1, 0); push(0, 32'hA2, 1);
    run_cycles(6);
    check("t1_count", out_q.size(), 3);
    check("t1_busy_cycles", busy_cycles, 3);
    for (int i = 0; i < out_q.size() && i < 3; i++) begin
      check($sformatf("t1_cyc%0d", i), out_q[i].cyc, i + 1);
      check($sformatf("t1_data%0d", i), out_q[i].data, 32'hA0 + i);
      check($sformatf("t1_user%0d", i), out_q[i].user, 0);
      check($sformatf("t1_last%0d", i), out_q[i].last, (i == 2));
    end

    // Round-robin tie: single-word entries alternate A,B with one idle cycle between
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h10 + i, 1);
      push(1, 32'h20 + i, 1);
    end
    run_cycles(18);
    check("t2_count", out_q.size(), 8);
    for (int k = 0; k < out_q.size() && k < 8; k++) begin
      check($sformatf("t2_cyc%0d", k), out_q[k].cyc, 2 * k + 1);
      check($sformatf("t2_user%0d", k), out_q[k].user, k % 2);
      check($sformatf("t2_data%0d", k), out_q[k].data,
            (k % 2 == 0) ? 32'h10 + k / 2 : 32'h20 + k / 2);
    end

    // B 4-word entry under toggling m_tready while A waits
    reset_dut();
    for (int i = 0; i < 4; i++) push(1, 32'h30 + i, (i == 3));
    push(0, 32'h40, 1);
    a_on = 1'b0;
    run_cycles(1);
    a_on = 1'b1;
    toggle_ready = 1'b1;
    run_cycles(16);
    check("t3_count", out_q.size(), 5);
    for (int i = 0; i < out_q.size() && i < 4; i++) begin
      check($sformatf("t3_bdata%0d", i), out_q[i].data, 32'h30 + i);
      check($sformatf("t3_buser%0d", i), out_q[i].user, 1);
    end
    check("t3_a_ready_early", a_rdy_early, 0);
    if (out_q.size() > 4) begin
      check("t3_a_user", out_q[4].user, 0);
      check("t3_a_data", out_q[4].data, 32'h40);
    end

    // enable dropped mid-entry: entry completes, then no further grant
    reset_dut();
    for (int i = 0; i < 5; i++) push(0, 32'h50 + i, (i == 4));
    push(0, 32'h55, 1);
    push(1, 32'h60, 1);
    run_cycles(3);
    enable = 1'b0;
    run_cycles(12);
    check("t4_count", out_q.size(), 5);
    for (int i = 0; i < out_q.size() && i < 5; i++)
      check($sformatf("t4_data%0d", i), out_q[i].data, 32'h50 + i);
    if (out_q.size() > 4) check("t4_last", out_q[4].last, 1);
    settle();
    check("t4_idle_m_tvalid", m_tvalid, 0);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_a_tready", s_a_tready, 0);
    check("t4_idle_b_tready", s_b_tready, 0);
    @(posedge clk); #1;

    // Reset mid-entry drops the grant; afterwards a tie goes to A
    reset_dut();
    for (int i = 0; i < 4; i++) push(0, 32'h70 + i, (i == 3));
    run_cycles(2);
    rst = 1'b1;
    run_cycles(1);
    rst = 1'b0;
    settle();
    check("t5_m_tvalid", m_tvalid, 0);
    check("t5_busy", busy, 0);
    qa.delete();
    drive();
    @(posedge clk); #1;
    clear_log();
    push(1, 32'h90, 1);
    push(0, 32'h80, 1);
    run_cycles(5);
    check("t5_count", out_q.size(), 2);
    if (out_q.size() > 1) begin
      check("t5_first_user", out_q[0].user, 0);
      check("t5_first_data", out_q[0].data, 32'h80);
      check("t5_second_user", out_q[1].user, 1);
    end

`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
    // Counters: 7 A and 2 B entries, clear priority, wrap
    reset_dut();
    settle();
    check("st_rst_a", count_a, 0);
    check("st_rst_b", count_b, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) push(0, 32'hB0 + i, 1);
    for (int i = 0; i < 2; i++) push(1, 32'hD0 + i, 1);
    run_cycles(24);
    check("st_count_a", count_a, 7);
    check("st_count_b", count_b, 2);
    push(0, 32'hC0, 1);
    run_cycles(1);
    clear_stats = 1'b1;
    run_cycles(1);
    clear_stats = 1'b0;
    settle();
    check("st_clear_a", count_a, 0);
    check("st_clear_b", count_b, 0);
    force dut.count_a = 32'hFFFF_FFFF;
    #1;
    release dut.count_a;
    @(posedge clk); #1;
    push(0, 32'hC1, 1);
    run_cycles(3);
    settle();
    check("st_wrap_a", count_a, 0);
    @(posedge clk); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
